// File: rtl/lut_mux_tree_if.sv
// lut_mux_tree_if: evaluation and serial-configuration signals of one LUT cell.
// Optional macro LUT_MUX_TREE_READBACK_EN adds the cfg_dout readback line.
interface lut_mux_tree_if #(
  parameter int K = 2
) ();
  logic         in_valid;
  logic [K-1:0] in;
  logic         out_valid;
  logic         out;
  logic         cfg_start;
  logic         cfg_valid;
  logic         cfg_bit;
  logic         cfg_busy;
  logic         cfg_done;
`ifdef LUT_MUX_TREE_READBACK_EN
  logic         cfg_dout;

  // Driver side: whoever feeds inputs and configuration bits.
  modport master (
    output in_valid, in, cfg_start, cfg_valid, cfg_bit,
    input  out_valid, out, cfg_busy, cfg_done, cfg_dout
  );

  // The LUT cell itself.
  modport slave (
    input  in_valid, in, cfg_start, cfg_valid, cfg_bit,
    output out_valid, out, cfg_busy, cfg_done, cfg_dout
  );
`else
  // Driver side: whoever feeds inputs and configuration bits.
  modport master (
    output in_valid, in, cfg_start, cfg_valid, cfg_bit,
    input  out_valid, out, cfg_busy, cfg_done
  );

  // The LUT cell itself.
  modport slave (
    input  in_valid, in, cfg_start, cfg_valid, cfg_bit,
    output out_valid, out, cfg_busy, cfg_done
  );
`endif
endinterface

// File: rtl/lut_mux_tree.sv
// lut_mux_tree: K-input programmable logic cell. The truth table feeds the leaves
// of a binary tree of 2:1 muxes; the table can be reloaded serially (MSB first)
// while the cell keeps evaluating with the old table until the last bit lands.
// Optional macro LUT_MUX_TREE_READBACK_EN: shift the old table out on cfg_dout
// while a new one is loaded, so cells can be chained and verified.

// Basic 2:1 mux used as the tree node.
module lut_mux_tree_mux2 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);
  assign y = sel ? d1 : d0;
endmodule

module lut_mux_tree #(
  parameter int            K    = 2,
  parameter logic [2**K-1:0] INIT = {1'b1, {(2**K-1){1'b0}}}
) (
  input  logic           clk,
  input  logic           rst_n,
  lut_mux_tree_if.slave  bus
);
  localparam int N  = 2**K;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t        state_q;
  logic [N-1:0]  lut_q;
  // Only N-1 bits need to be kept: the N-th bit goes straight into the table.
  logic [N-2:0]  shadow_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  shifted;

  // Heap-ordered tree: node 0 is the root, children of n are 2n+1 (sel=0) and
  // 2n+2 (sel=1); leaves N-1 .. 2N-2 hold table entries 0 .. N-1.
  logic node [0:2*N-2];

  assign shifted = {shadow_q, bus.cfg_bit};

  for (genvar i = 0; i < N; i++) begin : g_leaf
    assign node[N-1+i] = lut_q[i];
  end

  // Depth d (root = 0) selects on in[K-1-d], so the leaf-level muxes use in[0].
  for (genvar d = 0; d < K; d++) begin : g_level
    for (genvar m = 0; m < (1 << d); m++) begin : g_node
      localparam int NODE = (1 << d) - 1 + m;
      lut_mux_tree_mux2 u_mux (
        .d0  (node[2*NODE+1]),
        .d1  (node[2*NODE+2]),
        .sel (bus.in[K-1-d]),
        .y   (node[NODE])
      );
    end
  end

  // Registered evaluation: out follows the tree when in_valid, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out       <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.out <= node[0];
      end
    end
  end

`ifdef LUT_MUX_TREE_READBACK_EN
  logic [K-1:0] rd_idx;
  assign rd_idx = K'(N-1) - cnt_q[K-1:0];
`endif

  // Configuration FSM: cfg_start (re)starts a load, N accepted bits commit the table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lut_q        <= INIT;
      shadow_q     <= '0;
      cnt_q        <= '0;
      bus.cfg_busy <= 1'b0;
      bus.cfg_done <= 1'b0;
`ifdef LUT_MUX_TREE_READBACK_EN
      bus.cfg_dout <= 1'b0;
`endif
    end else if (bus.cfg_start) begin
      state_q      <= LOAD;
      shadow_q     <= '0;
      cnt_q        <= '0;
      bus.cfg_busy <= 1'b1;
      bus.cfg_done <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          bus.cfg_done <= 1'b0;
          if (bus.cfg_valid) begin
            shadow_q <= shifted[N-2:0];
            cnt_q    <= cnt_q + 1'b1;
`ifdef LUT_MUX_TREE_READBACK_EN
            bus.cfg_dout <= lut_q[rd_idx];
`endif
            if (cnt_q == CW'(N-1)) begin
              lut_q        <= shifted;
              state_q      <= DONE;
              bus.cfg_busy <= 1'b0;
              bus.cfg_done <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q      <= IDLE;
          bus.cfg_busy <= 1'b0;
          bus.cfg_done <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          bus.cfg_busy <= 1'b0;
          bus.cfg_done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lut_mux_tree.sv
// tb_lut_mux_tree: drives a K=2 (AND) cell and a K=3 (parity) cell with the same
// stimulus and compares both against a table/bit-list model of the cell.
// Build with LUT_MUX_TREE_READBACK_EN defined to also check cfg_dout.
module tb_lut_mux_tree;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;

  lut_mux_tree_if #(.K(2)) bus2 ();
  lut_mux_tree_if #(.K(3)) bus3 ();

  lut_mux_tree #(.K(2), .INIT(4'b1000)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  lut_mux_tree #(.K(3), .INIT(8'h96))   dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  // Free-running clock.
  always #5 clk = ~clk;

  int         nsz [2] = '{4, 8};
  logic [7:0] m_tbl [2];
  bit         m_load [2];
  int         m_got [2];
  bit   [7:0] m_bits [2];
  bit         e_ov [2];
  bit         e_out [2];
  bit         e_busy [2];
  bit         e_done [2];
  bit         e_dout [2];

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle, got, exp);
    end
  endtask

  task automatic modelReset();
    m_tbl[0] = 8'h08;
    m_tbl[1] = 8'h96;
    for (int c = 0; c < 2; c++) begin
      m_load[c] = 1'b0;
      m_got[c]  = 0;
      m_bits[c] = '0;
      e_ov[c]   = 1'b0;
      e_out[c]  = 1'b0;
      e_busy[c] = 1'b0;
      e_done[c] = 1'b0;
      e_dout[c] = 1'b0;
    end
  endtask

  // One clock edge of the cell as described: evaluate on the old table, then
  // collect config bits into a list and rebuild the table once N have arrived.
  task automatic modelStep(input bit iv, input bit [2:0] inv, input bit st, input bit cv, input bit cb);
    for (int c = 0; c < 2; c++) begin
      int idx;
      int n;
      logic [7:0] newt;
      n = nsz[c];
      idx = (c == 0) ? int'(inv[1:0]) : int'(inv);
      e_ov[c] = iv;
      if (iv) e_out[c] = m_tbl[c][idx];
      e_done[c] = 1'b0;
      if (st) begin
        m_load[c] = 1'b1;
        m_got[c]  = 0;
      end else if (m_load[c] && cv) begin
        e_dout[c] = m_tbl[c][n-1-m_got[c]];
        m_bits[c][m_got[c]] = cb;
        m_got[c]++;
        if (m_got[c] == n) begin
          newt = '0;
          for (int i = 0; i < n; i++) newt[n-1-i] = m_bits[c][i];
          m_tbl[c]  = newt;
          m_load[c] = 1'b0;
          e_done[c] = 1'b1;
        end
      end
      e_busy[c] = m_load[c];
    end
  endtask

  task automatic checkAll();
    checkOutput("k2_out_valid", bus2.out_valid, e_ov[0]);
    checkOutput("k2_out",       bus2.out,       e_out[0]);
    checkOutput("k2_cfg_busy",  bus2.cfg_busy,  e_busy[0]);
    checkOutput("k2_cfg_done",  bus2.cfg_done,  e_done[0]);
    checkOutput("k3_out_valid", bus3.out_valid, e_ov[1]);
    checkOutput("k3_out",       bus3.out,       e_out[1]);
    checkOutput("k3_cfg_busy",  bus3.cfg_busy,  e_busy[1]);
    checkOutput("k3_cfg_done",  bus3.cfg_done,  e_done[1]);
`ifdef LUT_MUX_TREE_READBACK_EN
    checkOutput("k2_cfg_dout",  bus2.cfg_dout,  e_dout[0]);
    checkOutput("k3_cfg_dout",  bus3.cfg_dout,  e_dout[1]);
`endif
  endtask

  task automatic applyStimulus(input bit iv, input bit [2:0] inv, input bit st, input bit cv, input bit cb);
    bus2.in_valid = iv;  bus2.in = inv[1:0];
    bus3.in_valid = iv;  bus3.in = inv;
    bus2.cfg_start = st; bus2.cfg_valid = cv; bus2.cfg_bit = cb;
    bus3.cfg_start = st; bus3.cfg_valid = cv; bus3.cfg_bit = cb;
    @(posedge clk);
    cycle++;
    modelStep(iv, inv, st, cv, cb);
    #1;
    checkAll();
  endtask

  task automatic sweep(input int count);
    for (int i = 0; i < count; i++) applyStimulus(1'b1, 3'(i), 1'b0, 1'b0, 1'b0);
  endtask

  // Main sequence: directed scenarios first, then a randomized run.
  initial begin
    bit [3:0] orb;
    bit [7:0] k3b;
    bus2.in_valid = 0; bus2.in = '0; bus2.cfg_start = 0; bus2.cfg_valid = 0; bus2.cfg_bit = 0;
    bus3.in_valid = 0; bus3.in = '0; bus3.cfg_start = 0; bus3.cfg_valid = 0; bus3.cfg_bit = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll();
    rst_n = 1'b1;

    // AND sweep, then idle cycles holding out.
    sweep(4);
    applyStimulus(0, 3'd0, 0, 0, 0);
    applyStimulus(0, 3'd2, 0, 0, 0);

    // Load OR back to back; the last bit shares its cycle with an in=2 evaluation.
    applyStimulus(0, 3'd0, 1, 0, 0);
    orb = 4'b1110;
    for (int i = 0; i < 4; i++) applyStimulus(1, (i == 3) ? 3'd2 : 3'(i), 0, 1, orb[3-i]);
    sweep(4);

    // Partial load with gaps, restart, then XOR.
    applyStimulus(0, 3'd0, 1, 0, 0);
    applyStimulus(0, 3'd0, 0, 1, 0);
    applyStimulus(0, 3'd0, 0, 0, 1);
    applyStimulus(0, 3'd0, 0, 1, 1);
    applyStimulus(0, 3'd0, 0, 0, 0);
    applyStimulus(0, 3'd0, 1, 0, 0);
    applyStimulus(0, 3'd0, 0, 1, 0);
    applyStimulus(0, 3'd0, 0, 1, 1);
    applyStimulus(0, 3'd0, 0, 1, 1);
    applyStimulus(0, 3'd0, 0, 1, 0);
    sweep(4);

    // cfg_start with cfg_valid: that bit must be dropped, so 0,0,0,1 gives NOR.
    applyStimulus(0, 3'd0, 1, 1, 1);
    applyStimulus(0, 3'd0, 0, 1, 0);
    applyStimulus(0, 3'd0, 0, 1, 0);
    applyStimulus(0, 3'd0, 0, 1, 0);
    applyStimulus(0, 3'd0, 0, 1, 1);
    sweep(4);

    // Asynchronous reset in the middle of a load, with out = 1 beforehand.
    applyStimulus(1, 3'd1, 1, 0, 0);
    applyStimulus(1, 3'd0, 0, 1, 1);
    applyStimulus(1, 3'd0, 0, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    #2;
    rst_n = 1'b1;
    sweep(4);

    // Parity sweep on the K=3 cell, load 8'h80, sweep again.
    sweep(8);
    applyStimulus(0, 3'd0, 1, 0, 0);
    k3b = 8'h80;
    for (int i = 0; i < 8; i++) applyStimulus(0, 3'd0, 0, 1, k3b[7-i]);
    sweep(8);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6),
                    1'($urandom_range(0, 1)));
    end
    applyStimulus(0, 3'd0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
